// File: rtl/mul_sequencer_pkg.sv
// Shared constants and FSM state encoding for the multi-cycle MUL unit.
package mul_sequencer_pkg;

  localparam logic [5:0] FUNCT_MUL  = 6'b011000;
  localparam logic [5:0] ALUCTL_MUL = 6'b011000;

  localparam int DATA_W  = 32;
  localparam int COUNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-add multiplier datapath: operand/accumulator/count registers and the adder.
module mul_shift_add_dp
  import mul_sequencer_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] acc_next_o,
  output logic              last_o,
  output logic              zero_op_o
);

  logic [DATA_W-1:0]  mcand_q, mcand_d;
  logic [DATA_W-1:0]  mplier_q, mplier_d;
  logic [DATA_W-1:0]  acc_q, acc_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [DATA_W-1:0]  addend;

  // Sum wraps modulo 2^32, so the low word is right for signed and unsigned operands.
  assign addend     = mplier_q[0] ? mcand_q : '0;
  assign acc_next_o = acc_q + addend;
  assign last_o     = (mplier_q[DATA_W-1:1] == '0) || (count_q == 5'd31);
  assign zero_op_o  = (a_i == '0) || (b_i == '0);

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    if (load_i) begin
      mcand_d  = a_i;
      mplier_d = b_i;
      acc_d    = '0;
      count_d  = '0;
    end else if (step_i) begin
      acc_d    = acc_next_o;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      count_d  = count_q + 5'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mul_sequencer.sv
// Pipeline-stalling MUL sequencer: FSM controlling a shift-add datapath.
module mul_sequencer
  import mul_sequencer_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic              Flush,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              Stall,
  output logic              Done,
  output logic [DATA_W-1:0] Result
);

  state_t            state_q, state_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              load, step;
  logic [DATA_W-1:0] acc_next;
  logic              last, zero_op;

  mul_shift_add_dp u_dp (
    .clk_i      (Clk),
    .rst_i      (Rst),
    .load_i     (load),
    .step_i     (step),
    .a_i        (A),
    .b_i        (B),
    .acc_next_o (acc_next),
    .last_o     (last),
    .zero_op_o  (zero_op)
  );

  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    result_d = result_q;
    Stall    = 1'b0;
    load     = 1'b0;
    step     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Start && !Flush) begin
          Stall = 1'b1;
          load  = 1'b1;
          if (zero_op) begin
            state_d  = DONE;
            done_d   = 1'b1;
            result_d = '0;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (Flush) begin
          state_d = IDLE;
        end else begin
          Stall = 1'b1;
          step  = 1'b1;
          if (last) begin
            state_d  = DONE;
            done_d   = 1'b1;
            result_d = acc_next;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // The pipeline must not be frozen while the unit is being reset.
    if (Rst) begin
      Stall = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= IDLE;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign Done   = done_q;
  assign Result = result_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer: latency, results, flush, reset.
module tb_mul_sequencer;

  logic        Clk = 1'b0;
  logic        Rst, Start, Flush;
  logic [31:0] A, B;
  logic        Stall, Done;
  logic [31:0] Result;

  int checks = 0;
  int passed = 0;

  mul_sequencer dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .Start  (Start),
    .Flush  (Flush),
    .A      (A),
    .B      (B),
    .Stall  (Stall),
    .Done   (Done),
    .Result (Result)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Move to the next cycle; inputs settle and outputs are sampled 1-2 time units after the edge.
  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input int exp_stall,
                         input logic [31:0] exp_res, input bit hold, input string tag);
    int  n;
    bit  early_done;
    n = 0;
    early_done = 1'b0;
    Start = 1'b1;
    A = a;
    B = b;
    #1;
    while (Stall === 1'b1 && n < 40) begin
      if (Done === 1'b1) early_done = 1'b1;
      next_cycle();
      n++;
    end
    check({tag, " stall cycles"}, n, exp_stall);
    check({tag, " no early done"}, {31'd0, early_done}, 32'd0);
    check({tag, " done"}, {31'd0, Done}, 32'd1);
    check({tag, " result"}, Result, exp_res);
    $display("mul %s: A=0x%08h B=0x%08h stall=%0d result=0x%08h", tag, a, b, n, Result);
    if (!hold) Start = 1'b0;
    next_cycle();
    #1;
    check({tag, " done drops"}, {31'd0, Done}, 32'd0);
    check({tag, " idle stall"}, {31'd0, Stall}, {31'd0, hold});
    check({tag, " result held"}, Result, exp_res);
  endtask

  initial begin
    Rst = 1'b1; Start = 1'b1; Flush = 1'b0; A = 32'd3; B = 32'd5;
    #1;
    check("stall in reset", {31'd0, Stall}, 32'd0);
    next_cycle();
    next_cycle();
    check("stall in reset 2", {31'd0, Stall}, 32'd0);
    Rst = 1'b0; Start = 1'b0;
    #1;
    check("reset done", {31'd0, Done}, 32'd0);
    check("reset result", Result, 32'd0);
    check("reset stall", {31'd0, Stall}, 32'd0);

    run_mul(32'd3, 32'd5, 4, 32'h0000000F, 1'b0, "3x5");

    // Flush on the third BUSY cycle of 9*0xFF.
    Start = 1'b1; A = 32'd9; B = 32'h000000FF;
    next_cycle();
    next_cycle();
    next_cycle();
    Flush = 1'b1;
    #1;
    check("flush stall", {31'd0, Stall}, 32'd0);
    next_cycle();
    Flush = 1'b0; Start = 1'b0;
    #1;
    check("flush idle stall", {31'd0, Stall}, 32'd0);
    check("flush no done", {31'd0, Done}, 32'd0);
    check("flush result kept", Result, 32'h0000000F);
    $display("flush mid-busy: stall=%0d done=%0d result=0x%08h", Stall, Done, Result);

    // Flush wins over Start in IDLE: no capture, so the unit never goes busy.
    Start = 1'b1; Flush = 1'b1; A = 32'd7; B = 32'd7;
    #1;
    check("flush+start stall", {31'd0, Stall}, 32'd0);
    next_cycle();
    Start = 1'b0; Flush = 1'b0;
    #1;
    check("flush+start idle", {31'd0, Stall}, 32'd0);
    next_cycle();
    check("flush+start no done", {31'd0, Done}, 32'd0);
    $display("flush with start in idle: stall=%0d done=%0d", Stall, Done);

    run_mul(32'd0, 32'h00001234, 1, 32'h00000000, 1'b0, "0x1234");
    run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'h00000001, 1'b0, "ffff^2");
    run_mul(32'd7, 32'd6, 4, 32'h0000002A, 1'b1, "7x6");
    run_mul(32'd2, 32'h80000000, 33, 32'h00000000, 1'b0, "2x8000");
    run_mul(32'h0000000B, 32'd0, 1, 32'h00000000, 1'b0, "0xB_x0");
    run_mul(32'hFFFFFFFD, 32'd4, 4, 32'hFFFFFFF4, 1'b0, "neg3x4");
    run_mul(32'd3, 32'd5, 4, 32'h0000000F, 1'b0, "3x5 again");

    // Reset in the middle of a BUSY sequence.
    Start = 1'b1; A = 32'd9; B = 32'h000000FF;
    next_cycle();
    next_cycle();
    Rst = 1'b1;
    #1;
    check("rst mid-busy stall", {31'd0, Stall}, 32'd0);
    next_cycle();
    Rst = 1'b0; Start = 1'b0;
    #1;
    check("post-rst stall", {31'd0, Stall}, 32'd0);
    check("post-rst done", {31'd0, Done}, 32'd0);
    check("post-rst result", Result, 32'd0);
    next_cycle();
    check("post-rst still idle", {31'd0, Done}, 32'd0);
    $display("reset mid-busy: stall=%0d done=%0d result=0x%08h", Stall, Done, Result);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
